data_mem_arbiter: RTL and testbench

//  Shares one single-port data memory between two requesters: port 0 = load/store stage
//  (LS), port 1 = instruction fetch (IF, read-only). Grants one access per cycle, tracks
//  one outstanding read through a fixed-latency memory, routes read data back to its

---
 rtl/data_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port, fixed-latency data memory between the
// load/store stage (LS, port 0) and instruction fetch (IF, port 1, read-only).
// One grant per cycle, one outstanding read, read data routed back to its owner,
// and IF is guaranteed a grant after STARVE_LIMIT consecutive lost arbitrations.
//
// Ports:
//   i_clk, i_rst_n                     clock (rising edge), async active-low reset
//   i_ls_req/addr/wdata/we/mask        LS request (held until o_ls_gnt)
//   o_ls_gnt, o_ls_rvalid, o_ls_rdata  LS grant and read response
//   i_if_req/addr                      IF read request (held until o_if_gnt)
//   o_if_gnt, o_if_rvalid, o_if_rdata  IF grant and read response
//   o_mem_addr/write_data/read_en/write_en/data_mask   memory command (grant cycle only)
//   i_mem_read_data                    memory read data, valid READ_LATENCY after read_en
module data_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ls_req,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    input  logic              i_ls_we,
    input  logic [1:0]        i_ls_mask,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DATA_W-1:0] o_ls_rdata,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_read_en,
    output logic              o_mem_write_en,
    output logic [1:0]        o_mem_data_mask,
    input  logic [DATA_W-1:0] i_mem_read_data
);

    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic OWNER_LS = 1'b0;
    localparam logic OWNER_IF = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             owner_q, owner_d;

    logic resp_cycle;
    logic grant_ok;
    logic if_starved;
    logic ls_win;
    logic if_win;
    logic read_grant;

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            owner_q      <= OWNER_LS;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    // Arbitration, memory command, response routing and next-state
    always_comb begin
        state_d          = state_q;
        lat_cnt_d        = lat_cnt_q;
        starve_cnt_d     = starve_cnt_q;
        owner_d          = owner_q;
        o_ls_gnt         = 1'b0;
        o_if_gnt         = 1'b0;
        o_ls_rvalid      = 1'b0;
        o_if_rvalid      = 1'b0;
        o_ls_rdata       = '0;
        o_if_rdata       = '0;
        o_mem_addr       = '0;
        o_mem_write_data = '0;
        o_mem_read_en    = 1'b0;
        o_mem_write_en   = 1'b0;
        o_mem_data_mask  = 2'b00;

        // Response cycle doubles as a grant slot so reads can issue back-to-back.
        // Reset gating keeps every combinational output low while reset is held.
        resp_cycle = i_rst_n && (state_q == ST_BUSY) && (lat_cnt_q == LAT_W'(1));
        grant_ok   = i_rst_n && ((state_q == ST_IDLE) || resp_cycle);
        if_starved = (starve_cnt_q == STV_W'(STARVE_LIMIT));
        ls_win     = grant_ok && i_ls_req && !(i_if_req && if_starved);
        if_win     = grant_ok && i_if_req && !ls_win;
        read_grant = (ls_win && !i_ls_we) || if_win;

        if (ls_win) begin
            o_ls_gnt         = 1'b1;
            o_mem_addr       = i_ls_addr;
            o_mem_write_data = i_ls_wdata;
            o_mem_read_en    = !i_ls_we;
            o_mem_write_en   = i_ls_we;
            o_mem_data_mask  = i_ls_mask;
        end else if (if_win) begin
            o_if_gnt         = 1'b1;
            o_mem_addr       = i_if_addr;
            o_mem_read_en    = 1'b1;
            o_mem_data_mask  = 2'b11;
        end

        if (resp_cycle) begin
            if (owner_q == OWNER_IF) begin
                o_if_rvalid = 1'b1;
                o_if_rdata  = i_mem_read_data;
            end else begin
                o_ls_rvalid = 1'b1;
                o_ls_rdata  = i_mem_read_data;
            end
        end

        // Writes complete in the grant cycle and leave the FSM untouched
        if (read_grant) begin
            state_d   = ST_BUSY;
            lat_cnt_d = LAT_W'(READ_LATENCY);
            owner_d   = if_win ? OWNER_IF : OWNER_LS;
        end else if (state_q == ST_BUSY) begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
            if (resp_cycle) begin
                state_d = ST_IDLE;
            end
        end

        // Count IF losses to LS; saturate so the starved IF keeps priority
        if (if_win) begin
            starve_cnt_d = '0;
        end else if (ls_win && i_if_req && !if_starved) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3. Inputs change on the falling edge; combinational outputs
// are sampled 2 time units later, well before the next rising edge.
module tb_data_mem_arbiter;

    logic clk;
    int   checks;
    int   failures;

    // Instance A: READ_LATENCY = 1
    logic        rst_n;
    logic        ls_req, ls_we, if_req;
    logic [31:0] ls_addr, ls_wdata, if_addr, mem_rdata;
    logic [1:0]  ls_mask;
    logic        ls_gnt, ls_rvalid, if_gnt, if_rvalid, mem_re, mem_we;
    logic [31:0] ls_rdata, if_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_mask;

    // Instance B: READ_LATENCY = 3
    logic        rst3_n;
    logic        ls_req3, ls_we3, if_req3;
    logic [31:0] ls_addr3, ls_wdata3, if_addr3, mem_rdata3;
    logic [1:0]  ls_mask3;
    logic        ls_gnt3, ls_rvalid3, if_gnt3, if_rvalid3, mem_re3, mem_we3;
    logic [31:0] ls_rdata3, if_rdata3, mem_addr3, mem_wdata3;
    logic [1:0]  mem_mask3;

    data_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .STARVE_LIMIT(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ls_req(ls_req), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .i_ls_we(ls_we), .i_ls_mask(ls_mask),
        .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .o_mem_addr(mem_addr), .o_mem_write_data(mem_wdata),
        .o_mem_read_en(mem_re), .o_mem_write_en(mem_we),
        .o_mem_data_mask(mem_mask), .i_mem_read_data(mem_rdata)
    );

    data_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .STARVE_LIMIT(4)
    ) dut3 (
        .i_clk(clk), .i_rst_n(rst3_n),
        .i_ls_req(ls_req3), .i_ls_addr(ls_addr3), .i_ls_wdata(ls_wdata3),
        .i_ls_we(ls_we3), .i_ls_mask(ls_mask3),
        .o_ls_gnt(ls_gnt3), .o_ls_rvalid(ls_rvalid3), .o_ls_rdata(ls_rdata3),
        .i_if_req(if_req3), .i_if_addr(if_addr3),
        .o_if_gnt(if_gnt3), .o_if_rvalid(if_rvalid3), .o_if_rdata(if_rdata3),
        .o_mem_addr(mem_addr3), .o_mem_write_data(mem_wdata3),
        .o_mem_read_en(mem_re3), .o_mem_write_en(mem_we3),
        .o_mem_data_mask(mem_mask3), .i_mem_read_data(mem_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (inputs are driven right after it)
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n  = 1'b0; rst3_n = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_mask = 2'b11;
        if_req = 1'b1; if_addr = 32'h0; mem_rdata = 32'hFFFF_FFFF;
        ls_req3 = 1'b0; ls_we3 = 1'b0; ls_addr3 = 32'h0; ls_wdata3 = 32'h0; ls_mask3 = 2'b11;
        if_req3 = 1'b0; if_addr3 = 32'h0; mem_rdata3 = 32'h0;

        // Reset: every output low even with requests and memory data present
        step(); settle();
        chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);

        step();
        rst_n = 1'b1; rst3_n = 1'b1;
        ls_req = 1'b0; if_req = 1'b0; mem_rdata = 32'h0;

        // 1: LS word read of 0x100, memory returns 0xDEADBEEF one cycle later
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_mask = 2'b11;
        settle();
        chk("t1_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("t1_mem_re", 32'(mem_re), 32'd1);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_mask", 32'(mem_mask), 32'd3);
        step();
        ls_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_ls_rvalid", 32'(ls_rvalid), 32'd1);
        chk("t1_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
        chk("t1_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("t1_if_rdata", if_rdata, 32'd0);
        chk("t1_mem_re_idle", 32'(mem_re), 32'd0);

        // 2: LS byte write 0x200 = 0x12345678
        step();
        mem_rdata = 32'h0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_mask = 2'b01;
        settle();
        chk("t2_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("t2_mem_we", 32'(mem_we), 32'd1);
        chk("t2_mem_re", 32'(mem_re), 32'd0);
        chk("t2_mem_mask", 32'(mem_mask), 32'd1);
        chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
        step();
        ls_req = 1'b0; ls_we = 1'b0; ls_mask = 2'b11; mem_rdata = 32'h5555_AAAA;
        settle();
        chk("t2_no_rvalid", 32'(ls_rvalid), 32'd0);
        chk("t2_mem_we_off", 32'(mem_we), 32'd0);

        // 3: both request every cycle; IF wins after four LS grants
        mem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            ls_req = 1'b1; ls_addr = 32'h300; if_req = 1'b1; if_addr = 32'h40;
            settle();
            chk("t3_ls_gnt", 32'(ls_gnt), 32'd1);
            chk("t3_if_gnt", 32'(if_gnt), 32'd0);
        end
        step();
        settle();
        chk("t3_if_gnt_starved", 32'(if_gnt), 32'd1);
        chk("t3_ls_gnt_starved", 32'(ls_gnt), 32'd0);
        chk("t3_if_mem_addr", mem_addr, 32'h40);
        chk("t3_if_mem_mask", 32'(mem_mask), 32'd3);
        chk("t3_ls_rvalid", 32'(ls_rvalid), 32'd1);
        step();
        mem_rdata = 32'h1111_2222;
        settle();
        chk("t3_cnt_cleared_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("t3_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t3_if_rdata", if_rdata, 32'h1111_2222);
        chk("t3_ls_rdata_nonowner", ls_rdata, 32'd0);
        step();
        ls_req = 1'b0; if_req = 1'b0; mem_rdata = 32'h3333_4444;
        settle();
        chk("t3_last_ls_rvalid", 32'(ls_rvalid), 32'd1);
        chk("t3_last_if_rvalid", 32'(if_rvalid), 32'd0);

        // 4: back-to-back IF read then LS read
        step();
        if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h0;
        settle();
        chk("t4_if_gnt", 32'(if_gnt), 32'd1);
        step();
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h180; mem_rdata = 32'hAAAA_0001;
        settle();
        chk("t4_ls_gnt_b2b", 32'(ls_gnt), 32'd1);
        chk("t4_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t4_if_rdata", if_rdata, 32'hAAAA_0001);
        chk("t4_ls_rvalid_early", 32'(ls_rvalid), 32'd0);
        step();
        ls_req = 1'b0; mem_rdata = 32'hBBBB_0002;
        settle();
        chk("t4_ls_rvalid", 32'(ls_rvalid), 32'd1);
        chk("t4_ls_rdata", ls_rdata, 32'hBBBB_0002);
        chk("t4_if_rvalid_off", 32'(if_rvalid), 32'd0);

        // 5: READ_LATENCY=3 read stalls the pending IF request until the response cycle
        step();
        ls_req3 = 1'b1; ls_addr3 = 32'h500; if_req3 = 1'b1; if_addr3 = 32'h60;
        settle();
        chk("t5_ls_gnt", 32'(ls_gnt3), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            step();
            ls_req3 = 1'b0;
            settle();
            chk("t5_stall_if_gnt", 32'(if_gnt3), 32'd0);
            chk("t5_stall_mem_re", 32'(mem_re3), 32'd0);
            chk("t5_stall_rvalid", 32'(ls_rvalid3), 32'd0);
        end
        step();
        mem_rdata3 = 32'hCAFE_F00D;
        settle();
        chk("t5_ls_rvalid", 32'(ls_rvalid3), 32'd1);
        chk("t5_ls_rdata", ls_rdata3, 32'hCAFE_F00D);
        chk("t5_if_gnt", 32'(if_gnt3), 32'd1);
        chk("t5_if_mem_addr", mem_addr3, 32'h60);
        step();
        if_req3 = 1'b0; mem_rdata3 = 32'h0;
        settle();
        chk("t5_if_rvalid_early", 32'(if_rvalid3), 32'd0);
        step();
        step();
        mem_rdata3 = 32'h7777_8888;
        settle();
        chk("t5_if_rvalid", 32'(if_rvalid3), 32'd1);
        chk("t5_if_rdata", if_rdata3, 32'h7777_8888);

        // 6: reset during an outstanding latency-3 read
        step();
        ls_req3 = 1'b1; ls_addr3 = 32'h700; mem_rdata3 = 32'h9999_0000;
        settle();
        chk("t6_ls_gnt", 32'(ls_gnt3), 32'd1);
        step();
        ls_req3 = 1'b0; if_req3 = 1'b1; rst3_n = 1'b0;
        settle();
        chk("t6_rst_if_gnt", 32'(if_gnt3), 32'd0);
        chk("t6_rst_mem_re", 32'(mem_re3), 32'd0);
        chk("t6_rst_mem_addr", mem_addr3, 32'd0);
        chk("t6_rst_ls_rvalid", 32'(ls_rvalid3), 32'd0);
        step();
        rst3_n = 1'b1; if_req3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t6_post_ls_rvalid", 32'(ls_rvalid3), 32'd0);
            chk("t6_post_if_rvalid", 32'(if_rvalid3), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
